serial_addsub: RTL and testbench
================================

Name: serial_addsub

Overview:
- Bit-serial adder/subtractor built around the half-adder/half-subtractor cell pair.
- Sequences two WIDTH-bit operands LSB-first through a single-bit add/subtract slice with a registered carry/borrow.
- Produces the full-width result plus final carry/borrow.
- Sits directly upstream of the bit-level adder cells: feeds them one bit pair per clock and consumes their sum/carry outputs.

Parameters:
- WIDTH, 8, operand and result width in bits (>=2)

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request to begin an operation; sampled only in IDLE
- sub  input  1  0 = add (a+b), 1 = subtract (a-b); latched with start
- a  input  WIDTH  operand A; latched with start
- b  input  WIDTH  operand B; latched with start
- busy  output  1  high while an operation is in progress (RUN state)
- done  output  1  one-cycle pulse: result/carry_out valid and newly updated
- result  output  WIDTH  sum or difference, unsigned modulo 2^WIDTH
- carry_out  output  1  final carry (add) or final borrow (sub)

Behaviour:
- Clocking and reset: one clock, clk; reset is asynchronous and active-low, rst_n.
- Reset values: state=IDLE; busy=0, done=0, result=0, carry_out=0; internal shift registers, bit counter and carry/borrow flop all 0.
- States:
  - IDLE: start=1 at a rising edge loads a, b and sub into internal registers, clears the carry/borrow flop and the bit counter, and moves to RUN. start=0 stays in IDLE.
  - RUN: busy=1. Each edge:
    - processes bit pair (A[0], B[0]) with the registered carry/borrow c.
    - Add: s = A0^B0^c; c' = A0&B0 | c&(A0^B0).
    - Sub: d = A0^B0^c; c' = ~A0&B0 | c&~(A0^B0).
    - Result bit shifts into the MSB of the internal result shift register; A and B shift right by one; counter increments.
    - On the edge where counter == WIDTH-1 (the WIDTH-th RUN edge), the completed word is copied to result, c' to carry_out, and the FSM moves to DONE.
  - DONE: done=1, busy=0 for exactly one cycle, then unconditionally IDLE.
- Latency: start accepted at edge k -> done high from edge k+WIDTH to edge k+WIDTH+1. Next start is accepted no earlier than edge k+WIDTH+2.
- start in RUN or DONE is ignored; there is no queueing. a, b and sub may change freely after acceptance without effect.
- result and carry_out change only on entry to DONE and hold until the next completed operation; they are never updated mid-operation.
- Subtraction is unsigned: carry_out=1 iff a < b. The result is the two's-complement difference modulo 2^WIDTH.
- Asserting rst_n low at any time, including mid-RUN, aborts immediately to reset values. No done pulse is produced for the aborted operation.
- Control logic has no combinational path from inputs to outputs; all outputs are registered.

Test Plan:
- Add, WIDTH=8: a=0x3C, b=0x0F, sub=0, start pulse -> busy high for 8 cycles; done one cycle at start edge+8; result=0x4B, carry_out=0.
- Add overflow: a=0xFF, b=0x01, sub=0 -> result=0x00, carry_out=1. Then a=0xFF, b=0xFF -> result=0xFE, carry_out=1.
- Subtract: a=0x05, b=0x03, sub=1 -> result=0x02, carry_out=0. Then a=0x03, b=0x05, sub=1 -> result=0xFE, carry_out=1. Then a=b=0x80 -> result=0x00, carry_out=0.
- Ignored start: during RUN of 0x10+0x20, pulse start with a=0xAA, b=0x55, sub=1 -> exactly one done; result=0x30, carry_out=0; FSM returns to IDLE.
- Reset mid-op: start 0x3C+0x0F, drop rst_n at RUN cycle 4 -> busy=0, done=0, result=0, carry_out=0 immediately. No done follows after release. A fresh start with 0x01+0x01 -> result=0x02.
- Back-to-back with start held high continuously: a=0x01, b=0x02 -> done every WIDTH+2 cycles; result=0x03 each time; busy low during the DONE and IDLE cycles.

Source files
------------

// File: rtl/serial_addsub.sv
// Bit-serial add/subtract: WIDTH-bit operands processed LSB-first, one bit pair per clock.
// Latency: start accepted at edge k -> done pulse from edge k+WIDTH, next start accepted at k+WIDTH+2.
// Backpressure: none; start is only sampled in IDLE and is ignored (not queued) while busy or done.
module serial_addsub #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry_out
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] r_sh_q, r_sh_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             sub_q, sub_d;
    logic             c_q, c_d;
    logic             carry_q, carry_d;

    // One-bit add/subtract slice on the current LSB pair and the registered carry/borrow.
    logic a0, b0, bit_sum, bit_cout;
    always_comb begin
        a0      = a_sh_q[0];
        b0      = b_sh_q[0];
        bit_sum = a0 ^ b0 ^ c_q;
        if (sub_q) begin
            bit_cout = (~a0 & b0) | (c_q & ~(a0 ^ b0));
        end else begin
            bit_cout = (a0 & b0) | (c_q & (a0 ^ b0));
        end
    end

    // Next-state and datapath update: load on accepted start, shift while running, publish on last bit.
    always_comb begin
        state_d  = state_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        r_sh_d   = r_sh_q;
        result_d = result_q;
        cnt_d    = cnt_q;
        sub_d    = sub_q;
        c_d      = c_q;
        carry_d  = carry_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_sh_d  = a;
                    b_sh_d  = b;
                    sub_d   = sub;
                    c_d     = 1'b0;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                r_sh_d = {bit_sum, r_sh_q[WIDTH-1:1]};
                a_sh_d = {1'b0, a_sh_q[WIDTH-1:1]};
                b_sh_d = {1'b0, b_sh_q[WIDTH-1:1]};
                c_d    = bit_cout;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == LAST_BIT) begin
                    // The final bit completes the word; the shifted register is the answer.
                    result_d = {bit_sum, r_sh_q[WIDTH-1:1]};
                    carry_d  = bit_cout;
                    state_d  = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with asynchronous abort to reset values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            r_sh_q   <= '0;
            result_q <= '0;
            cnt_q    <= '0;
            sub_q    <= 1'b0;
            c_q      <= 1'b0;
            carry_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            r_sh_q   <= r_sh_d;
            result_q <= result_d;
            cnt_q    <= cnt_d;
            sub_q    <= sub_d;
            c_q      <= c_d;
            carry_q  <= carry_d;
        end
    end

    // Outputs come straight from registers; status is a decode of the state flop only.
    always_comb begin
        busy      = (state_q == RUN);
        done      = (state_q == DONE);
        result    = result_q;
        carry_out = carry_q;
    end

endmodule

// File: tb/tb_serial_addsub.sv
module tb_serial_addsub;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         start = 1'b0;
    logic         sub = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy, done, carry_out;
    logic [W-1:0] result;

    int n_vec = 0;
    int n_err = 0;
    bit cmp_en = 1'b0;

    serial_addsub #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .a(a), .b(b),
        .busy(busy), .done(done), .result(result), .carry_out(carry_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: phase 0 = idle, 1..W = running, W+1 = done; answer from plain arithmetic.
    int           m_phase = 0;
    logic [W:0]   m_pend = '0;
    logic [W-1:0] m_result = '0;
    logic         m_carry = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase  = 0;
            m_result = '0;
            m_carry  = 1'b0;
        end else if (m_phase == 0) begin
            if (start) begin
                m_pend  = sub ? ({1'b0, a} - {1'b0, b}) : ({1'b0, a} + {1'b0, b});
                m_phase = 1;
            end
        end else if (m_phase < W) begin
            m_phase++;
        end else if (m_phase == W) begin
            m_phase  = W + 1;
            m_result = m_pend[W-1:0];
            m_carry  = m_pend[W];
        end else begin
            m_phase = 0;
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("busy", {31'b0, busy}, {31'b0, (m_phase >= 1 && m_phase <= W)});
            chk("done", {31'b0, done}, {31'b0, (m_phase == W + 1)});
            chk("result", {24'b0, result}, {24'b0, m_result});
            chk("carry_out", {31'b0, carry_out}, {31'b0, m_carry});
        end
    end

    // Issue one operation, wait (bounded) for done, check latency and literal answer.
    task automatic run_op(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic isub,
                          input logic [W-1:0] er, input logic ec, input string nm);
        int n;
        @(negedge clk); #1;
        start = 1'b1; a = ia; b = ib; sub = isub;
        @(negedge clk); #1;
        start = 1'b0; a = W'($urandom); b = W'($urandom); sub = 1'($urandom);
        n = 0;
        while (!done && n < 4 * W) begin
            @(negedge clk);
            n++;
        end
        chk({nm, "_latency"}, n, W);
        chk({nm, "_result"}, {24'b0, result}, {24'b0, er});
        chk({nm, "_carry"}, {31'b0, carry_out}, {31'b0, ec});
    endtask

    initial begin
        int dones;
        int last_t;
        int n;
        #1 rst_n = 1'b0;
        #1;
        chk("rst_busy", {31'b0, busy}, 0);
        chk("rst_done", {31'b0, done}, 0);
        chk("rst_result", {24'b0, result}, 0);
        chk("rst_carry", {31'b0, carry_out}, 0);
        cmp_en = 1'b1;
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(negedge clk);

        run_op(8'h3C, 8'h0F, 1'b0, 8'h4B, 1'b0, "add_basic");
        run_op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, "add_ovf1");
        run_op(8'hFF, 8'hFF, 1'b0, 8'hFE, 1'b1, "add_ovf2");
        run_op(8'h05, 8'h03, 1'b1, 8'h02, 1'b0, "sub_pos");
        run_op(8'h03, 8'h05, 1'b1, 8'hFE, 1'b1, "sub_neg");
        run_op(8'h80, 8'h80, 1'b1, 8'h00, 1'b0, "sub_eq");

        // Start pulsed during RUN must be ignored.
        @(negedge clk); #1;
        start = 1'b1; a = 8'h10; b = 8'h20; sub = 1'b0;
        @(negedge clk); #1;
        start = 1'b0;
        dones = 0;
        repeat (3) @(negedge clk);
        #1 start = 1'b1; a = 8'hAA; b = 8'h55; sub = 1'b1;
        @(negedge clk); #1 start = 1'b0;
        repeat (W + 4) begin
            @(negedge clk);
            if (done) begin
                dones++;
                chk("ign_result", {24'b0, result}, 32'h30);
                chk("ign_carry", {31'b0, carry_out}, 0);
            end
        end
        chk("ign_done_count", dones, 1);
        chk("ign_idle", {30'b0, busy, done}, 0);

        // Reset in the middle of an operation aborts it.
        @(negedge clk); #1;
        start = 1'b1; a = 8'h3C; b = 8'h0F; sub = 1'b0;
        @(negedge clk); #1 start = 1'b0;
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("abort_busy", {31'b0, busy}, 0);
        chk("abort_done", {31'b0, done}, 0);
        chk("abort_result", {24'b0, result}, 0);
        chk("abort_carry", {31'b0, carry_out}, 0);
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        dones = 0;
        repeat (W + 4) begin
            @(negedge clk);
            if (done) dones++;
        end
        chk("abort_no_done", dones, 0);
        run_op(8'h01, 8'h01, 1'b0, 8'h02, 1'b0, "after_abort");

        // Start held high: back-to-back operations every W+2 cycles.
        @(negedge clk); #1;
        start = 1'b1; a = 8'h01; b = 8'h02; sub = 1'b0;
        dones = 0;
        last_t = -1;
        for (int i = 1; i <= 3 * (W + 2); i++) begin
            @(negedge clk);
            if (done) begin
                dones++;
                chk("b2b_result", {24'b0, result}, 32'h03);
                if (last_t >= 0) chk("b2b_period", i - last_t, W + 2);
                last_t = i;
            end
        end
        chk("b2b_done_count", dones, 3);
        #1 start = 1'b0;
        repeat (W + 4) @(negedge clk);

        // Randomized traffic, checked every cycle by the model.
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk); #1;
            start = ($urandom_range(0, 2) == 0);
            a = W'($urandom);
            b = W'($urandom);
            sub = 1'($urandom);
            if (i == 1500) begin
                rst_n = 1'b0;
                @(negedge clk); #1 rst_n = 1'b1;
            end
        end
        #1 start = 1'b0;
        n = 0;
        while ((busy || done) && n < 4 * W) begin
            @(negedge clk);
            n++;
        end
        chk("final_idle", {30'b0, busy, done}, 0);
        @(negedge clk);
        cmp_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
